// File: rtl/acia_save_buffer_if.sv
// Bus bundle for the ACIA save buffer: CPU transmit strobe, OSD capture
// option, HPS upload/read handshake and status outputs.
interface acia_save_buffer_if #(
  parameter int DEPTH_LOG2 = 12
);
  logic                  tx_wr;
  logic [7:0]            tx_data;
  logic                  save_enable;
  logic                  ioctl_upload;
  logic                  ioctl_rd;
  logic [15:0]           ioctl_addr;
  logic [7:0]            ioctl_din;
  logic                  ioctl_wait;
  logic [DEPTH_LOG2:0]   byte_count;
  logic                  full;
  logic                  overflow;
  logic                  capturing;

  modport master (
    output tx_wr, tx_data, save_enable, ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, byte_count, full, overflow, capturing
  );

  modport slave (
    input  tx_wr, tx_data, save_enable, ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, byte_count, full, overflow, capturing
  );
endinterface

// File: rtl/acia_save_buffer.sv
// Captures bytes written to the ACIA transmit register into a byte RAM and
// serves them back to the HPS during an upload session, padding with 8'h1A.
module acia_save_buffer #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                 clk,
  input  logic                 n_reset,
  acia_save_buffer_if.slave    bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_UPLOAD  = 2'd2;
  localparam int         AW         = DEPTH_LOG2;

  logic [1:0]  state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        save_en_q;
  logic        wait_q, wait_d;
  logic        hit_q, hit_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  ram_rd_q;
  logic [7:0]  ram [2**AW];

  logic save_rise;
  logic full;
  logic wr_en;
  logic rd_start;

  // Count never exceeds 2^AW, so its top bit alone marks a full buffer.
  assign full      = count_q[AW];
  assign save_rise = bus.save_enable & ~save_en_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wait_d     = wait_q;
    hit_d      = hit_q;
    din_d      = din_q;
    wr_en      = 1'b0;
    rd_start   = 1'b0;

    if (bus.ioctl_upload) begin
      state_d = ST_UPLOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (save_rise) begin
            state_d    = ST_CAPTURE;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
        ST_CAPTURE: if (!bus.save_enable) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end

    // An upload request wins over a same-cycle transmit strobe.
    if (state_q == ST_CAPTURE && !bus.ioctl_upload && bus.tx_wr) begin
      if (!full) begin
        wr_en   = 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (wait_q) begin
      wait_d = 1'b0;
      if (bus.ioctl_upload) din_d = hit_q ? ram_rd_q : 8'h1A;
    end else if (state_q == ST_UPLOAD && bus.ioctl_upload && bus.ioctl_rd) begin
      rd_start = 1'b1;
      wait_d   = 1'b1;
      hit_d    = 17'(bus.ioctl_addr) < 17'(count_q);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      save_en_q  <= 1'b0;
      wait_q     <= 1'b0;
      hit_q      <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      save_en_q  <= bus.save_enable;
      wait_q     <= wait_d;
      hit_q      <= hit_d;
      din_q      <= din_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)    ram[count_q[AW-1:0]] <= bus.tx_data;
    if (rd_start) ram_rd_q <= ram[bus.ioctl_addr[AW-1:0]];
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.byte_count = count_q;
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.capturing  = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_acia_save_buffer.sv
// Directed bench for acia_save_buffer at DEPTH_LOG2=4; read results are
// checked through a scoreboard queue filled from a small capture model.
module tb_acia_save_buffer;

  logic clk;
  logic n_reset;

  acia_save_buffer_if #(.DEPTH_LOG2(4)) bus ();

  acia_save_buffer #(.DEPTH_LOG2(4)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_mem [16];
  int         model_cnt    = 0;
  logic [7:0] last_din     = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit stored);
    bus.tx_data = b;
    bus.tx_wr   = 1'b1;
    tick();
    bus.tx_wr   = 1'b0;
    if (stored) begin
      model_mem[model_cnt[3:0]] = b;
      model_cnt++;
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input string tag);
    logic [7:0] e;
    logic [7:0] got;
    int n;
    e = (32'(addr) < model_cnt) ? model_mem[addr[3:0]] : 8'h1A;
    exp_q.push_back(e);
    bus.ioctl_addr = addr;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
    check({tag, " wait_hi"}, 32'(bus.ioctl_wait), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ioctl_wait !== 1'b0 && n < 8);
    check({tag, " wait_len"}, n, 1);
    got = bus.ioctl_din;
    check({tag, " din"}, 32'(got), 32'(exp_q.pop_front()));
    last_din = e;
    $display("[TB] read addr=%04h din=%02h", addr, got);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset          = 1'b0;
    bus.tx_wr        = 1'b0;
    bus.tx_data      = 8'h00;
    bus.save_enable  = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 16'h0000;
    repeat (3) tick();
    check("rst count", 32'(bus.byte_count), 0);
    check("rst capturing", 32'(bus.capturing), 0);
    check("rst overflow", 32'(bus.overflow), 0);
    check("rst wait", 32'(bus.ioctl_wait), 0);
    check("rst din", 32'(bus.ioctl_din), 0);
    check("rst full", 32'(bus.full), 0);
    n_reset = 1'b1;
    tick();

    // Capture three bytes
    bus.save_enable = 1'b1;
    tick();
    check("cap enter", 32'(bus.capturing), 1);
    model_cnt = 0;
    wr_byte(8'h41, 1);
    wr_byte(8'h42, 1);
    wr_byte(8'h0D, 1);
    check("cap count", 32'(bus.byte_count), 3);
    check("cap overflow", 32'(bus.overflow), 0);
    check("cap capturing", 32'(bus.capturing), 1);

    bus.save_enable = 1'b0;
    tick();
    check("idle exit", 32'(bus.capturing), 0);
    wr_byte(8'h77, 0);
    check("idle tx ignored", 32'(bus.byte_count), 3);
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("idle rd ignored", 32'(bus.ioctl_wait), 0);

    // Upload reads, including beyond count and high address bits
    bus.ioctl_upload = 1'b1;
    tick();
    wr_byte(8'h66, 0);
    check("upload tx ignored", 32'(bus.byte_count), 3);
    do_read(16'h0000, "rd0");
    do_read(16'h0001, "rd1");
    do_read(16'h0002, "rd2");
    do_read(16'h0003, "rd3");
    do_read(16'h8001, "rd_hi");
    bus.ioctl_upload = 1'b0;
    tick();

    // Re-arm, then upload request colliding with a transmit strobe
    bus.save_enable = 1'b1;
    tick();
    model_cnt = 0;
    check("rearm capturing", 32'(bus.capturing), 1);
    check("rearm count", 32'(bus.byte_count), 0);
    check("rearm overflow", 32'(bus.overflow), 0);
    wr_byte(8'hA0, 1);
    wr_byte(8'hA1, 1);
    bus.ioctl_upload = 1'b1;
    bus.tx_data      = 8'hA2;
    bus.tx_wr        = 1'b1;
    tick();
    bus.tx_wr        = 1'b0;
    check("prio count", 32'(bus.byte_count), 2);
    check("prio capturing", 32'(bus.capturing), 0);
    bus.save_enable = 1'b0;
    tick();
    bus.save_enable = 1'b1;
    tick();
    do_read(16'h0000, "prio rd0");
    do_read(16'h0002, "rearm old");
    bus.ioctl_upload = 1'b0;
    tick();
    tick();
    check("edge discarded", 32'(bus.capturing), 0);

    // Fill past capacity
    bus.save_enable = 1'b0;
    tick();
    bus.save_enable = 1'b1;
    tick();
    model_cnt = 0;
    check("fill start", 32'(bus.byte_count), 0);
    for (int i = 0; i < 17; i++) wr_byte(8'(8'h10 + i), i < 16);
    check("fill count", 32'(bus.byte_count), 16);
    check("fill full", 32'(bus.full), 1);
    check("fill overflow", 32'(bus.overflow), 1);
    bus.save_enable  = 1'b0;
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(16'h000F, "rd15");
    do_read(16'h0010, "rd16");

    // Upload drop aborts an in-flight read
    bus.ioctl_addr = 16'h0000;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_upload = 1'b0;
    check("abort wait_hi", 32'(bus.ioctl_wait), 1);
    tick();
    check("abort wait_lo", 32'(bus.ioctl_wait), 0);
    check("abort din held", 32'(bus.ioctl_din), 32'(last_din));

    // Reset in the middle of a read
    bus.ioctl_upload = 1'b1;
    tick();
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("rstrd wait_hi", 32'(bus.ioctl_wait), 1);
    n_reset = 1'b0;
    #1;
    check("rstrd wait", 32'(bus.ioctl_wait), 0);
    check("rstrd count", 32'(bus.byte_count), 0);
    check("rstrd overflow", 32'(bus.overflow), 0);
    check("rstrd din", 32'(bus.ioctl_din), 0);
    model_cnt = 0;

    // save_enable already high when reset releases
    bus.ioctl_upload = 1'b0;
    bus.save_enable  = 1'b1;
    tick();
    check("rst held idle", 32'(bus.capturing), 0);
    n_reset = 1'b1;
    tick();
    check("post-rst capture", 32'(bus.capturing), 1);
    wr_byte(8'h55, 1);
    bus.save_enable  = 1'b0;
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(16'h0000, "post rd0");
    do_read(16'h0001, "post rd1");
    bus.ioctl_upload = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/acia_save_buffer.md
ACIA_SAVE_BUFFER -- requirements
Module: acia_save_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning buffer capacity is 2^DEPTH_LOG2 bytes (4096 at default).
REQ-002 SHALL have port clk  input  1  system clock (clk_sys, 48 MHz); all logic on rising edge.
REQ-003 SHALL have port n_reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tx_wr  input  1  one-cycle strobe: CPU wrote ACIA transmit data register.
REQ-005 SHALL have port tx_data  input  8  byte written by CPU, valid when tx_wr=1.
REQ-006 SHALL have port save_enable  input  1  OSD "capture output" option level.
REQ-007 SHALL have port ioctl_upload  input  1  HPS upload (core-to-file) session active.
REQ-008 SHALL have port ioctl_rd  input  1  one-cycle HPS read request.
REQ-009 SHALL have port ioctl_addr  input  16  HPS byte address for read.
REQ-010 SHALL have port ioctl_din  output  8  read data to HPS.
REQ-011 SHALL have port ioctl_wait  output  1  read in progress; HPS stalls while high.
REQ-012 SHALL have port byte_count  output  DEPTH_LOG2+1  bytes captured (0..2^DEPTH_LOG2).
REQ-013 SHALL have port full  output  1  byte_count == 2^DEPTH_LOG2.
REQ-014 SHALL have port overflow  output  1  sticky: a byte was dropped because buffer full.
REQ-015 SHALL have port capturing  output  1  high while in CAPTURE state.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, UPLOAD, registered, with single-port-read/single-port-write byte RAM of 2^DEPTH_LOG2 entries.
REQ-017 SHALL register save_enable each cycle; IDLE->CAPTURE on its rising edge, clearing byte_count and overflow on that transition.
REQ-018 SHALL go CAPTURE->IDLE when save_enable is low; byte_count and RAM contents retained.
REQ-019 SHALL in CAPTURE, on tx_wr with full=0, write tx_data at address byte_count and increment byte_count in the same cycle (visible next cycle).
REQ-020 SHALL in CAPTURE, on tx_wr with full=1, drop the byte, hold byte_count, set overflow.
REQ-021 SHALL ignore tx_wr in IDLE and UPLOAD (no write, no count change, no overflow).
REQ-022 SHALL go from any state to UPLOAD while ioctl_upload=1 (priority over save_enable edge); UPLOAD->IDLE when ioctl_upload falls; a save_enable rising edge occurring during UPLOAD is discarded.
REQ-023 SHALL on ioctl_rd in UPLOAD at cycle T with ioctl_wait=0: ioctl_wait=1 at T+1, ioctl_din valid and ioctl_wait=0 at T+2; ioctl_din held until the next completed read.
REQ-024 SHALL return RAM[ioctl_addr] when ioctl_addr < byte_count, else 8'h1A (EOF pad), including any address with bits above DEPTH_LOG2-1 set.
REQ-025 SHALL ignore ioctl_rd outside UPLOAD or while ioctl_wait=1.
REQ-026 SHALL drive full and capturing as combinational decodes of registered state/count.
REQ-027 SHALL abort an in-flight read if ioctl_upload falls: ioctl_wait=0 next cycle.

Reset
REQ-028 SHALL on n_reset=0 asynchronously force state=IDLE, byte_count=0, overflow=0, ioctl_wait=0, ioctl_din=8'h00, registered save_enable=0; RAM contents undefined/not cleared.
REQ-029 SHALL, if save_enable is already high when n_reset deasserts, enter CAPTURE on the first cycle after reset (registered value 0 -> 1 is a rising edge).

Verification
REQ-030 Capture: save_enable 0->1, tx_wr with 8'h41,8'h42,8'h0D -> byte_count=3, capturing=1, overflow=0.
REQ-031 Upload: after REQ-030, save_enable=0, ioctl_upload=1, ioctl_rd at addr 0,1,2,3 -> ioctl_din 8'h41,8'h42,8'h0D,8'h1A, each with ioctl_wait high exactly one cycle.
REQ-032 Full: DEPTH_LOG2=4, 17 tx_wr strobes -> byte_count=16, full=1, overflow=1, addr 15 returns 16th byte.
REQ-033 Priority: ioctl_upload=1 during CAPTURE with tx_wr same cycle -> byte not stored, state UPLOAD, byte_count unchanged.
REQ-034 Reset mid-read: n_reset low at T+1 of a read -> ioctl_wait=0, byte_count=0, state IDLE immediately.
REQ-035 Re-arm: second save_enable rising edge after upload -> byte_count=0, overflow=0, old data returns 8'h1A.
